// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative unsigned MULTU/DIVU.
// Define ALU_MULDIV_EN to build the multiply/divide datapath; otherwise MULTU/DIVU act as reserved ops.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] CHi,
  output logic             Zero
);

  localparam logic [3:0] OP_ADDU  = 4'b0000;
  localparam logic [3:0] OP_SUBU  = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] res;
  logic             res_ok;
  logic             load_alu;
  logic             finish;

  always_comb begin
    res    = '0;
    res_ok = 1'b1;
    case (ALUOp)
      OP_ADDU: res = A + B;
      OP_SUBU: res = A - B;
      OP_OR:   res = A | B;
      OP_AND:  res = A & B;
      OP_XOR:  res = A ^ B;
      OP_NOR:  res = ~(A | B);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  res = A << B[SHW-1:0];
      OP_SRL:  res = A >> B[SHW-1:0];
      OP_SRA:  res = $signed(A) >>> B[SHW-1:0];
      default: res_ok = 1'b0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] hi_q, lo_q, dvs_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   sum, trial;
  logic             launch;

  // hi_q/lo_q hold {partial product, multiplier} or {remainder, dividend/quotient}.
  // A zero divisor never makes trial negative, so the quotient fills with ones and the remainder ends as A.
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        hi_n = trial[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n  = state;
    load_alu = 1'b0;
    launch   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (ALUOp == OP_MULTU || ALUOp == OP_DIVU) begin
            launch  = 1'b1;
            state_n = BUSY;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt == CW'(WIDTH-1)) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
    end else if (launch) begin
      cnt    <= '0;
      is_div <= (ALUOp == OP_DIVU);
      hi_q   <= '0;
      lo_q   <= A;
      dvs_q  <= B;
    end else if (state == BUSY) begin
      cnt  <= cnt + 1'b1;
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end
`else
  always_comb begin
    state_n  = IDLE;
    load_alu = (state == IDLE) && start;
    finish   = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      C    <= '0;
      CHi  <= '0;
      Zero <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= load_alu | finish;
      if (load_alu && res_ok) begin
        C    <= res;
        Zero <= (res == '0);
      end
`ifdef ALU_MULDIV_EN
      if (finish) begin
        C    <= lo_n;
        CHi  <= hi_n;
        Zero <= (lo_n == '0);
      end
`endif
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); expectations follow ALU_MULDIV_EN.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALUOp = '0;
  logic        busy, done, Zero;
  logic [31:0] C, CHi;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ALUOp(ALUOp),
    .busy(busy), .done(done), .C(C), .CHi(CHi), .Zero(Zero)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ALUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (C !== 32'h0 || CHi !== 32'h0 || Zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: C=%h CHi=%h Zero=%b busy=%b done=%b, want 0 0 1 0 0", C, CHi, Zero, busy, done);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    string       name;
  } vec_t;

  task automatic test_single();
    vec_t v[12];
    v[0]  = '{4'b0001, 32'd5,          32'd5,  32'h0000_0000, "subu_eq"};
    v[1]  = '{4'b0110, 32'hFFFF_FFFF,  32'd1,  32'h0000_0001, "slt_neg"};
    v[2]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,  32'h0000_0000, "sltu_big"};
    v[3]  = '{4'b1010, 32'h8000_0000,  32'd4,  32'hF800_0000, "sra"};
    v[4]  = '{4'b0000, 32'hFFFF_FFFF,  32'd1,  32'h0000_0000, "addu_wrap"};
    v[5]  = '{4'b0001, 32'd0,          32'd1,  32'hFFFF_FFFF, "subu_wrap"};
    v[6]  = '{4'b0010, 32'hF0F0_0000,  32'h0000_0F0F, 32'hF0F0_0F0F, "or"};
    v[7]  = '{4'b0011, 32'hFF00_FF00,  32'h0FF0_0FF0, 32'h0F00_0F00, "and"};
    v[8]  = '{4'b0100, 32'hAAAA_5555,  32'hFFFF_0000, 32'h5555_5555, "xor"};
    v[9]  = '{4'b0101, 32'h0000_0000,  32'h0000_0000, 32'hFFFF_FFFF, "nor"};
    v[10] = '{4'b1000, 32'h0000_0001,  32'hFFFF_FFFF, 32'h8000_0000, "sll_31"};
    v[11] = '{4'b1001, 32'h8000_0000,  32'd4,  32'h0800_0000, "srl"};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      total++;
      if (C !== v[i].c || Zero !== (v[i].c == 32'h0) || done !== 1'b1 || busy !== 1'b0 || CHi !== 32'h0) begin
        bad++;
        $display("FAIL %s: C=%h Zero=%b done=%b busy=%b CHi=%h, want C=%h Zero=%b done=1 busy=0 CHi=0",
                 v[i].name, C, Zero, done, busy, CHi, v[i].c, (v[i].c == 32'h0));
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || C !== 32'h0800_0000) begin
      bad++;
      $display("FAIL done_drop: done=%b C=%h, want done=0 C=08000000", done, C);
    end
  endtask

  task automatic test_reserved();
    issue(4'b0000, 32'h50, 32'h5);
    issue(4'b1101, 32'h0, 32'h0);
    total++;
    if (done !== 1'b1 || C !== 32'h55 || Zero !== 1'b0 || CHi !== 32'h0) begin
      bad++;
      $display("FAIL reserved: done=%b C=%h Zero=%b CHi=%h, want 1 00000055 0 0", done, C, Zero, CHi);
    end
    issue(4'b1111, 32'h0, 32'h0);
    total++;
    if (done !== 1'b1 || C !== 32'h55) begin
      bad++;
      $display("FAIL reserved_f: done=%b C=%h, want 1 00000055", done, C);
    end
  endtask

  task automatic test_muldiv();
`ifdef ALU_MULDIV_EN
    logic [31:0] exp_c[4], exp_h[4], ta[4], tb[4];
    logic [3:0]  top[4];
    int errs;
    top[0] = 4'b1011; ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd2;        exp_c[0] = 32'hFFFF_FFFE; exp_h[0] = 32'h1;
    top[1] = 4'b1100; ta[1] = 32'd100;       tb[1] = 32'd7;        exp_c[1] = 32'd14;        exp_h[1] = 32'd2;
    top[2] = 4'b1100; ta[2] = 32'd9;         tb[2] = 32'd0;        exp_c[2] = 32'hFFFF_FFFF; exp_h[2] = 32'd9;
    top[3] = 4'b1011; ta[3] = 32'h0001_0000; tb[3] = 32'h0001_0000; exp_c[3] = 32'h0;        exp_h[3] = 32'h1;
    for (int t = 0; t < 4; t++) begin
      issue(top[t], ta[t], tb[t]);
      errs = 0;
      for (int cyc = 1; cyc <= 32; cyc++) begin
        if (busy !== 1'b1 || done !== 1'b0) errs++;
        if (cyc == 10) begin start = 1'b1; ALUOp = 4'b0000; A = 32'd1; B = 32'd1; end
        if (cyc == 11) start = 1'b0;
        if (cyc < 32) @(negedge clk);
        else begin
          @(negedge clk);
          if (t == 1) begin start = 1'b1; ALUOp = 4'b0000; A = 32'd1; B = 32'd2; end
        end
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL md%0d_busy: bad busy/done cycles=%0d, want 0", t, errs);
      end
      total++;
      if (busy !== 1'b0 || done !== 1'b1 || C !== exp_c[t] || CHi !== exp_h[t] || Zero !== (exp_c[t] == 32'h0)) begin
        bad++;
        $display("FAIL md%0d_result: busy=%b done=%b C=%h CHi=%h Zero=%b, want 0 1 %h %h %b",
                 t, busy, done, C, CHi, Zero, exp_c[t], exp_h[t], (exp_c[t] == 32'h0));
      end
      if (t == 1) begin
        @(negedge clk);
        start = 1'b0;
        total++;
        if (C !== 32'd3 || done !== 1'b1 || CHi !== 32'd2 || busy !== 1'b0) begin
          bad++;
          $display("FAIL back_to_back: C=%h done=%b CHi=%h busy=%b, want 3 1 2 0", C, done, CHi, busy);
        end
      end
    end
`else
    issue(4'b0000, 32'h50, 32'h5);
    issue(4'b1011, 32'hFFFF_FFFF, 32'd2);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || C !== 32'h55 || CHi !== 32'h0 || Zero !== 1'b0) begin
      bad++;
      $display("FAIL multu_off: done=%b busy=%b C=%h CHi=%h Zero=%b, want 1 0 00000055 0 0", done, busy, C, CHi, Zero);
    end
    issue(4'b1100, 32'd100, 32'd7);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || C !== 32'h55 || CHi !== 32'h0) begin
      bad++;
      $display("FAIL divu_off: done=%b busy=%b C=%h CHi=%h, want 1 0 00000055 0", done, busy, C, CHi);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL off_idle: done=%b busy=%b, want 0 0", done, busy);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int dones;
    issue(4'b0000, 32'h1234, 32'h1);
    issue(4'b1011, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start = 1'b1; ALUOp = 4'b0000; A = 32'd7; B = 32'd7;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || C !== 32'h0 || CHi !== 32'h0 || Zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b C=%h CHi=%h Zero=%b, want 0 0 0 0 1", busy, done, C, CHi, Zero);
    end
    dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || C !== 32'h0) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_discard: cycles with activity after reset=%0d, want 0", dones);
    end
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_reserved();
    test_muldiv();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
